// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: operation encodings
// and the stack-occupancy width helper.
package pc_seq_pkg;

  // Encodings 6 and 7 are deliberately left out; the sequencer treats them as illegal.
  typedef enum logic [2:0] {
    INC    = 3'd0,
    JUMP   = 3'd1,
    BRANCH = 3'd2,
    CALL   = 3'd3,
    RET    = 3'd4,
    HOLD   = 3'd5
  } op_e;

  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO for the PC sequencer. Updates on the falling clock edge;
// the caller guarantees push and pop are never asserted together.
module pc_stack
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push,
  input  logic                                 pop,
  input  logic [ADDR_W-1:0]                    din,
  output logic [ADDR_W-1:0]                    dout,
  output logic [sp_width(STACK_DEPTH)-1:0]     count,
  output logic                                 full,
  output logic                                 empty
);

  localparam int CNT_W = sp_width(STACK_DEPTH);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];

  assign full  = (count == CNT_W'(STACK_DEPTH));
  assign empty = (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

  // NOTE: the storage array has no reset; entries at or above count are never
  // read, so clearing them would only add reset fan-out.
  always_ff @(negedge clk) begin
    if (push && !full) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (CNT_W'(i) == count) mem[i] <= din;
      end
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (CNT_W'(i + 1) == count) dout = mem[i];
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: INC/JUMP/BRANCH/CALL/RET/HOLD with a return-address
// stack, falling-edge state updates, one-edge ack and a sticky fault flag.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [2:0]                       op,
  input  logic [ADDR_W-1:0]                target,
  input  logic [ADDR_W-1:0]                offset,
  input  logic                             cond,
  output logic [ADDR_W-1:0]                pc_out,
  output logic                             ack,
  output logic [sp_width(STACK_DEPTH)-1:0] sp,
  output logic                             fault
);

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] stack_top;
  logic              push;
  logic              pop;
  logic              fault_set;
  logic              stack_full;
  logic              stack_empty;

  assign pc_inc = pc_out + ADDR_W'(1);

  pc_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stack_top),
    .count (sp),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    pc_next   = pc_out;
    push      = 1'b0;
    pop       = 1'b0;
    fault_set = 1'b0;
    if (en) begin
      case (op)
        INC:    pc_next = pc_inc;
        JUMP:   pc_next = target;
        BRANCH: pc_next = cond ? pc_out + offset : pc_inc;
        CALL: begin
          if (stack_full) begin
            fault_set = 1'b1;
          end else begin
            push    = 1'b1;
            pc_next = target;
          end
        end
        RET: begin
          if (stack_empty) begin
            fault_set = 1'b1;
          end else begin
            pop     = 1'b1;
            pc_next = stack_top;
          end
        end
        HOLD:    ;
        default: fault_set = 1'b1;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      pc_out <= RESET_VEC;
      ack    <= 1'b0;
      fault  <= 1'b0;
    end else begin
      pc_out <= pc_next;
      ack    <= en;
      if (fault_set) fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int              AW    = 8;
  localparam int              DEPTH = 4;
  localparam int              SPW   = $clog2(DEPTH + 1);
  localparam logic [AW-1:0]   RV    = 8'h00;
  localparam int unsigned     MOD   = 1 << AW;

  logic           clk    = 1'b1;
  logic           rst    = 1'b0;
  logic           en     = 1'b0;
  logic [2:0]     op     = 3'd5;
  logic [AW-1:0]  target = '0;
  logic [AW-1:0]  offset = '0;
  logic           cond   = 1'b0;
  logic [AW-1:0]  pc_out;
  logic           ack;
  logic [SPW-1:0] sp;
  logic           fault;

  pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .RESET_VEC(RV)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .op     (op),
    .target (target),
    .offset (offset),
    .cond   (cond),
    .pc_out (pc_out),
    .ack    (ack),
    .sp     (sp),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  int unsigned m_pc;
  bit          m_ack;
  bit          m_fault;
  int unsigned m_stk[$];

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [AW+SPW+1:0] mk(input int pc, input bit a, input int s, input bit f);
    return {AW'(pc), a, SPW'(s), f};
  endfunction

  function automatic logic [AW+SPW+1:0] obs();
    return {pc_out, ack, sp, fault};
  endfunction

  task automatic model_reset();
    m_pc    = RV;
    m_ack   = 1'b0;
    m_fault = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_step(input logic e, input logic [2:0] o, input logic [AW-1:0] t,
                            input logic [AW-1:0] f, input logic c);
    m_ack = e;
    if (e) begin
      case (o)
        3'd0: m_pc = (m_pc + 1) % MOD;
        3'd1: m_pc = t;
        3'd2: m_pc = c ? (m_pc + f) % MOD : (m_pc + 1) % MOD;
        3'd3: begin
          if (m_stk.size() == DEPTH) m_fault = 1'b1;
          else begin
            m_stk.push_back((m_pc + 1) % MOD);
            m_pc = t;
          end
        end
        3'd4: begin
          if (m_stk.size() == 0) m_fault = 1'b1;
          else m_pc = m_stk.pop_back();
        end
        3'd5: ;
        default: m_fault = 1'b1;
      endcase
    end
  endtask

  // Called at a rising edge: drive, let the falling edge act, sample at the next rising edge.
  task automatic step(input logic e, input logic [2:0] o, input logic [AW-1:0] t,
                      input logic [AW-1:0] f, input logic c);
    en = e; op = o; target = t; offset = f; cond = c;
    @(negedge clk);
    model_step(e, o, t, f, c);
    @(posedge clk);
  endtask

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [AW+SPW+1:0] want;
    #2;
    want = mk(RV, 0, 0, 0);
    n_total++;
    if (obs() !== want) $display("FAIL reset_async: got %h expected %h", obs(), want);
    else n_pass++;
    model_reset();
    @(posedge clk);
    rst = 1'b1;
  endtask

  task automatic test_inc();
    logic [AW+SPW+1:0] want;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) step(1'b1, INC, 8'h00, 8'h00, 1'b0);
      else       step(1'b0, JUMP, 8'hFF, 8'h00, 1'b0);
      want = mk((i < 3) ? i + 1 : 3, i < 3, 0, 0);
      n_total++;
      if (obs() !== want) $display("FAIL inc_step%0d: got %h expected %h", i, obs(), want);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [AW+SPW+1:0] want;
    int exp_pc [3] = '{8'hFE, 8'hFF, 8'h00};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) step(1'b1, JUMP, 8'hFE, 8'h00, 1'b0);
      else        step(1'b1, INC, 8'h00, 8'h00, 1'b0);
      want = mk(exp_pc[i], 1, 0, 0);
      n_total++;
      if (obs() !== want) $display("FAIL wrap_step%0d: got %h expected %h", i, obs(), want);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    logic [AW+SPW+1:0] want;
    int exp_pc [2] = '{8'h0C, 8'h0D};
    step(1'b1, JUMP, 8'h10, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, BRANCH, 8'h00, 8'hFC, i == 0);
      want = mk(exp_pc[i], 1, 0, 0);
      n_total++;
      if (obs() !== want) $display("FAIL branch_cond%0d: got %h expected %h", (i == 0), obs(), want);
      else n_pass++;
    end
  endtask

  task automatic test_call_ret();
    logic [AW+SPW+1:0] want;
    logic [2:0]    ops    [4] = '{CALL, CALL, RET, RET};
    logic [AW-1:0] tgts   [4] = '{8'h40, 8'h60, 8'h00, 8'h00};
    int            exp_pc [4] = '{8'h40, 8'h60, 8'h41, 8'h21};
    int            exp_sp [4] = '{1, 2, 1, 0};
    step(1'b1, JUMP, 8'h20, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ops[i], tgts[i], 8'h00, 1'b0);
      want = mk(exp_pc[i], 1, exp_sp[i], 0);
      n_total++;
      if (obs() !== want) $display("FAIL call_ret_step%0d: got %h expected %h", i, obs(), want);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [AW+SPW+1:0] want;
    logic [2:0]    ops    [10] = '{CALL, CALL, CALL, CALL, CALL, RET, RET, RET, RET, RET};
    logic [AW-1:0] tgts   [10] = '{8'h50, 8'h60, 8'h70, 8'h80, 8'h90,
                                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    int exp_pc [10] = '{8'h50, 8'h60, 8'h70, 8'h80, 8'h80, 8'h71, 8'h61, 8'h51, 8'h31, 8'h31};
    int exp_sp [10] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0};
    bit exp_f  [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    do_reset();
    step(1'b1, JUMP, 8'h30, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, ops[i], tgts[i], 8'h00, 1'b0);
      want = mk(exp_pc[i], 1, exp_sp[i], exp_f[i]);
      n_total++;
      if (obs() !== want) $display("FAIL overflow_step%0d: got %h expected %h", i, obs(), want);
      else n_pass++;
    end
  endtask

  task automatic test_illegal();
    logic [AW+SPW+1:0] want;
    logic [2:0] ops    [5] = '{HOLD, 3'd6, HOLD, 3'd7, INC};
    int         exp_pc [5] = '{8'h33, 8'h33, 8'h33, 8'h33, 8'h34};
    bit         exp_f  [5] = '{0, 1, 1, 1, 1};
    do_reset();
    step(1'b1, JUMP, 8'h33, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, ops[i], 8'hAA, 8'h55, 1'b1);
      want = mk(exp_pc[i], 1, 0, exp_f[i]);
      n_total++;
      if (obs() !== want) $display("FAIL illegal_step%0d: got %h expected %h", i, obs(), want);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    logic [AW+SPW+1:0] want;
    do_reset();
    step(1'b1, JUMP, 8'h20, 8'h00, 1'b0);
    step(1'b1, CALL, 8'h40, 8'h00, 1'b0);
    step(1'b1, CALL, 8'h60, 8'h00, 1'b0);
    want = mk(8'h60, 1, 2, 0);
    n_total++;
    if (obs() !== want) $display("FAIL mid_reset_pre: got %h expected %h", obs(), want);
    else n_pass++;
    en  = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    want = mk(RV, 0, 0, 0);
    n_total++;
    if (obs() !== want) $display("FAIL mid_reset_async: got %h expected %h", obs(), want);
    else n_pass++;
    @(posedge clk);
    rst = 1'b1;
    step(1'b1, RET, 8'h00, 8'h00, 1'b0);
    want = mk(RV, 1, 0, 1);
    n_total++;
    if (obs() !== want) $display("FAIL mid_reset_ret: got %h expected %h", obs(), want);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [AW+SPW+1:0] want;
    logic              e;
    logic [2:0]        o;
    int                r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      if (r < 3)      o = CALL;
      else if (r < 5) o = RET;
      else            o = 3'($urandom_range(0, 7));
      step(e, o, 8'($urandom), 8'($urandom), 1'($urandom));
      want = mk(m_pc, m_ack, m_stk.size(), m_fault);
      n_total++;
      if (obs() !== want) $display("FAIL random_step%0d op=%0d en=%b: got %h expected %h",
                                   i, o, e, obs(), want);
      else n_pass++;
      if (m_fault && $urandom_range(0, 15) == 0) do_reset();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_inc();
    test_wrap();
    test_branch();
    test_call_ret();
    test_overflow();
    test_illegal();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, program-counter width in bits (4..16).
REQ-002 Parameter STACK_DEPTH, default 4, return-address stack entries (1..16).
REQ-003 Parameter RESET_VEC, default 0, ADDR_W-bit pc_out value after reset.
REQ-004 clk  input  1  clock; all state updates on the falling edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  request; an operation is accepted on any falling edge with en=1.
REQ-007 op  input  3  operation code: INC, JUMP, BRANCH, CALL, RET, HOLD.
REQ-008 target  input  ADDR_W  absolute address for JUMP/CALL.
REQ-009 offset  input  ADDR_W  two's-complement displacement for BRANCH.
REQ-010 cond  input  1  branch condition; BRANCH taken only when cond=1.
REQ-011 pc_out  output  ADDR_W  current program counter.
REQ-012 ack  output  1  high for exactly one cycle after each accepted operation.
REQ-013 sp  output  clog2(STACK_DEPTH+1)  stack occupancy.
REQ-014 fault  output  1  sticky error flag: overflow, underflow or illegal op.

Function
REQ-015 With en=0: pc_out, stack and sp hold; ack=0 at the next falling edge.
REQ-016 With en=1: the op is executed and ack=1 at the same falling edge; pc_out is valid with ack (latency 1 edge, no bubbles; back-to-back ops accepted every cycle).
REQ-017 INC: pc_out <= pc_out+1, modulo 2^ADDR_W (all-ones wraps to 0, fault unaffected).
REQ-018 JUMP: pc_out <= target.
REQ-019 BRANCH: cond=1 -> pc_out <= pc_out+offset modulo 2^ADDR_W; cond=0 -> pc_out <= pc_out+1.
REQ-020 CALL: pushes pc_out+1 (wrapped), pc_out <= target, sp increments.
REQ-021 RET: pc_out <= top of stack, sp decrements.
REQ-022 HOLD: pc_out unchanged; ack still asserted.
REQ-023 CALL at sp=STACK_DEPTH: no push, pc_out unchanged, sp unchanged, fault <= 1, ack=1.
REQ-024 RET at sp=0: pc_out unchanged, sp unchanged, fault <= 1, ack=1.
REQ-025 Unused op encodings behave as HOLD and set fault.
REQ-026 fault clears only on reset.
REQ-027 Stack contents beyond sp are don't-care and are never observable on pc_out.

Reset
REQ-028 rst=0 asynchronously forces pc_out=RESET_VEC, ack=0, sp=0, fault=0, independent of clk.
REQ-029 Reset asserted mid-sequence discards all pending stack entries; the first operation after deassertion is treated as issued from a fresh state.
REQ-030 Stack storage array is not reset.

Structure
REQ-031 Package pc_seq_pkg holds the op encoding constants (INC=0, JUMP=1, BRANCH=2, CALL=3, RET=4, HOLD=5; 6 and 7 illegal).
REQ-032 The return-address LIFO is one sub-module, pc_stack (push, pop, data in/out, count, full, empty), parametrised by ADDR_W and STACK_DEPTH.
REQ-033 Next-PC selection is combinational in pc_sequencer; only pc_out, ack, fault and the stack are registered.

Verification
REQ-034 Reset, then 3x INC with ADDR_W=8 -> pc_out 1,2,3, ack high each cycle; en=0 for one cycle -> ack=0, pc_out stays 3.
REQ-035 JUMP target=0xFE, then INC, INC -> pc_out 0xFE, 0xFF, 0x00; fault=0.
REQ-036 At pc_out=0x10: BRANCH offset=0xFC, cond=1 -> pc_out=0x0C; BRANCH offset=0xFC, cond=0 -> pc_out=0x0D.
REQ-037 At pc_out=0x20: CALL 0x40, CALL 0x60, RET, RET -> pc_out 0x40, 0x60, 0x41, 0x21; sp 1, 2, 1, 0.
REQ-038 STACK_DEPTH=4: five CALLs -> fifth leaves pc_out and sp=4 unchanged, fault=1; then RET at sp=0 after draining -> fault remains 1, pc_out holds.
REQ-039 Assert rst between falling edges after two CALLs -> pc_out=RESET_VEC and sp=0 immediately; a subsequent RET sets fault.
